audio_level_reader: RTL and testbench
=====================================

AUDIO_LEVEL_READER -- requirements
Module: audio_level_reader

Interface
REQ-001 SHALL have parameter WINDOW, default 512: samples per measurement window; legal range 2..65535.
REQ-002 SHALL have parameter THRESH_HI, default 16'h2000: level at or above which loud sets.
REQ-003 SHALL have parameter THRESH_LO, default 16'h1000: level below which loud clears; must be at most THRESH_HI.
REQ-004 SHALL have port clk  input  1  single system clock (CLOCK_50 domain); all logic is on its rising edge.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  high = consume codec samples; low = idle.
REQ-007 SHALL have port read_ready  input  1  codec ADC FIFO holds at least one sample.
REQ-008 SHALL have port readdata_left  input  24  left ADC sample, two's complement.
REQ-009 SHALL have port readdata_right  input  24  right ADC sample, two's complement.
REQ-010 SHALL have port read  output  1  one-cycle pop pulse to the codec.
REQ-011 SHALL have port level  output  16  peak magnitude of the last completed window.
REQ-012 SHALL have port level_valid  output  1  one-cycle pulse when level updates.
REQ-013 SHALL have port loud  output  1  hysteresis flag derived from level.

Function
REQ-014 SHALL implement a 3-state FSM with states IDLE, ACK and GAP; all outputs SHALL be registered.
REQ-015 IDLE: if enable=1 and read_ready=1 at an edge, SHALL latch both readdata buses and go to ACK; otherwise SHALL stay in IDLE.
REQ-016 ACK: read SHALL be 1 for exactly this one cycle, then the FSM SHALL go to GAP; read SHALL be 0 in every other state.
REQ-017 GAP: SHALL process the latched sample and return to IDLE; read_ready SHALL be ignored in GAP, so pops are spaced at least 3 cycles apart.
REQ-018 Per-channel magnitude SHALL be |x| as a 23-bit value; -8388608 SHALL saturate to 8388607.
REQ-019 Sample magnitude SHALL be max(|L|, |R|) bits [22:7], giving 16 bits.
REQ-020 peak register: on GAP, peak SHALL become max(peak, sample magnitude).
REQ-021 Sample counter SHALL run 0..WINDOW-1; on GAP it SHALL increment, and when it equals WINDOW-1 it SHALL wrap to 0.
REQ-022 On the wrap GAP edge, level SHALL take max(peak, current magnitude), peak SHALL clear to 0, and level_valid SHALL pulse 1 in the following cycle.
REQ-023 loud SHALL update on the same edge as level, using the new level value: set if new level >= THRESH_HI; clear if new level < THRESH_LO; hold otherwise.
REQ-024 Latency: read_ready high in IDLE at edge N gives read=1 during cycle N..N+1, with GAP processing at edge N+2; on a window's last sample, level and level_valid are visible after edge N+2.
REQ-025 enable going low SHALL let an in-flight ACK/GAP complete.
REQ-026 While enable is low in IDLE, counter and peak SHALL clear to 0; level and loud SHALL hold.
REQ-027 read_ready falling during ACK SHALL have no effect: read is still pulsed once and the latched data is used.
REQ-028 Boundary magnitude equal to THRESH_HI SHALL set loud; a magnitude equal to THRESH_LO SHALL NOT clear it.

Reset
REQ-029 resetn=0 SHALL immediately, without waiting for a clock, force: FSM to IDLE, read=0, level=0, level_valid=0, loud=0, peak=0, counter=0, latched data=0.
REQ-030 Reset asserted mid-ACK SHALL drop read in the same cycle; no partial window SHALL survive reset.
REQ-031 After resetn rises, the first pop SHALL require a fresh read_ready sample in IDLE.

Verification
REQ-032 Handshake: WINDOW=4, read_ready held 1, enable=1 -> read pulses at cycles 1, 4, 7, 10 (period 3, width 1); level_valid pulses one cycle after the 4th GAP.
REQ-033 Peak: WINDOW=4, samples L=24'h010000, 24'hFF0000, 24'h000100, 24'h000000 with R=0 -> level=16'h0200, and peak clears for the next window.
REQ-034 Saturation/stereo: L=24'h800000, R=24'h000080 -> sample magnitude 16'hFFFF; with L=0, R=24'h7FFF80 -> 16'hFFFF.
REQ-035 Hysteresis, with defaults: window levels 16'h2000, 16'h1800, 16'h1000, 16'h0FFF -> loud=1, 1, 1, 0.
REQ-036 Reset mid-operation: resetn pulled low during ACK after 2 of 4 samples -> read=0 immediately, all outputs 0; a full 4 new samples are required before the next level_valid.
REQ-037 Enable gating: enable=0 with read_ready=1 for 20 cycles -> read stays 0; enable=0 after a partial window -> counter restarts at 0 when re-enabled.

Source files
------------

// File: rtl/audio_level_reader.sv
// Pops stereo samples from the codec ADC FIFO and tracks the per-window peak magnitude,
// publishing it as a level with a one-cycle valid pulse and a hysteresis "loud" flag.
module audio_level_reader #(
  parameter int unsigned WINDOW    = 512,
  parameter logic [15:0] THRESH_HI = 16'h2000,
  parameter logic [15:0] THRESH_LO = 16'h1000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        read_ready,
  input  logic [23:0] readdata_left,
  input  logic [23:0] readdata_right,
  output logic        read,
  output logic [15:0] level,
  output logic        level_valid,
  output logic        loud
);

  localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        read_q, read_d;
  logic [23:0] left_q, left_d;
  logic [23:0] right_q, right_d;
  logic [15:0] peak_q, peak_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] level_q, level_d;
  logic        valid_q, valid_d;
  logic        loud_q, loud_d;

  logic [22:0] mag_l_s;
  logic [22:0] mag_r_s;
  logic [22:0] mag_max_s;
  logic [15:0] cur_mag_s;
  logic [15:0] win_max_s;
  logic        loud_next_s;

  // The most negative code has no positive twin in 23 bits, so it saturates.
  function automatic logic [22:0] abs23(input logic [23:0] x);
    logic [23:0] neg;
    neg = 24'd0;
    if (x == 24'h800000) begin
      abs23 = 23'h7FFFFF;
    end else if (x[23]) begin
      neg   = ~x + 24'd1;
      abs23 = neg[22:0];
    end else begin
      abs23 = x[22:0];
    end
  endfunction

  function automatic logic [15:0] max16(input logic [15:0] a, input logic [15:0] b);
    if (a >= b) begin
      max16 = a;
    end else begin
      max16 = b;
    end
  endfunction

  // Magnitude of the latched stereo sample and the candidate window peak.
  always_comb begin
    mag_l_s     = abs23(left_q);
    mag_r_s     = abs23(right_q);
    mag_max_s   = (mag_l_s >= mag_r_s) ? mag_l_s : mag_r_s;
    cur_mag_s   = mag_max_s[22:7];
    win_max_s   = max16(peak_q, cur_mag_s);
    if (win_max_s >= THRESH_HI) begin
      loud_next_s = 1'b1;
    end else if (win_max_s < THRESH_LO) begin
      loud_next_s = 1'b0;
    end else begin
      loud_next_s = loud_q;
    end
  end

  // Pop handshake FSM plus peak/window bookkeeping.
  always_comb begin
    state_d = state_q;
    read_d  = 1'b0;
    left_d  = left_q;
    right_d = right_q;
    peak_d  = peak_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    valid_d = 1'b0;
    loud_d  = loud_q;
    case (state_q)
      IDLE: begin
        if (enable && read_ready) begin
          left_d  = readdata_left;
          right_d = readdata_right;
          read_d  = 1'b1;
          state_d = ACK;
        end else if (!enable) begin
          cnt_d  = 16'd0;
          peak_d = 16'd0;
        end else begin
          state_d = IDLE;
        end
      end
      ACK: begin
        state_d = GAP;
      end
      GAP: begin
        state_d = IDLE;
        if (cnt_q == WIN_LAST) begin
          cnt_d   = 16'd0;
          peak_d  = 16'd0;
          level_d = win_max_s;
          valid_d = 1'b1;
          loud_d  = loud_next_s;
        end else begin
          cnt_d  = cnt_q + 16'd1;
          peak_d = win_max_s;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      read_q  <= 1'b0;
      left_q  <= 24'd0;
      right_q <= 24'd0;
      peak_q  <= 16'd0;
      cnt_q   <= 16'd0;
      level_q <= 16'd0;
      valid_q <= 1'b0;
      loud_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      read_q  <= read_d;
      left_q  <= left_d;
      right_q <= right_d;
      peak_q  <= peak_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      valid_q <= valid_d;
      loud_q  <= loud_d;
    end
  end

  assign read        = read_q;
  assign level       = level_q;
  assign level_valid = valid_q;
  assign loud        = loud_q;

endmodule

// File: tb/tb_audio_level_reader.sv
// Directed bench for audio_level_reader with WINDOW=4 and default thresholds.
module tb_audio_level_reader;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        read_ready;
  logic [23:0] l_in;
  logic [23:0] r_in;
  logic        read;
  logic [15:0] level;
  logic        level_valid;
  logic        loud;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  audio_level_reader #(.WINDOW(4)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .enable         (enable),
    .read_ready     (read_ready),
    .readdata_left  (l_in),
    .readdata_right (r_in),
    .read           (read),
    .level          (level),
    .level_valid    (level_valid),
    .loud           (loud)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn     = 1'b0;
    read_ready = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  // Offers one sample, waits for the pop, then scrambles the bus so only latched data counts.
  task automatic pop_sample(input logic [23:0] l, input logic [23:0] r, input string tag);
    bit seen;
    seen       = 1'b0;
    l_in       = l;
    r_in       = r;
    read_ready = 1'b1;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (read === 1'b1) seen = 1'b1;
    end
    check({tag, "_pop_seen"}, {31'd0, seen}, 32'd1);
    read_ready = 1'b0;
    l_in       = 24'h5A5A5A;
    r_in       = 24'hA5A5A5;
    tick();
    tick();
  endtask

  // One window: a lead sample then three zero samples.
  task automatic window4(input logic [23:0] l, input logic [23:0] r,
                         input logic [15:0] exp_level, input logic exp_loud, input string tag);
    pop_sample(l, r, tag);
    check({tag, "_valid_early"}, {31'd0, level_valid}, 32'd0);
    pop_sample(24'd0, 24'd0, tag);
    pop_sample(24'd0, 24'd0, tag);
    pop_sample(24'd0, 24'd0, tag);
    check({tag, "_valid"}, {31'd0, level_valid}, 32'd1);
    check({tag, "_level"}, {16'd0, level}, {16'd0, exp_level});
    check({tag, "_loud"}, {31'd0, loud}, {31'd0, exp_loud});
  endtask

  initial begin
    logic [12:0] rd_pat;
    logic [12:0] vd_pat;
    bit          any_read;

    resetn     = 1'b0;
    enable     = 1'b0;
    read_ready = 1'b0;
    l_in       = 24'd0;
    r_in       = 24'd0;
    #1;
    check("rst_read", {31'd0, read}, 32'd0);
    check("rst_level", {16'd0, level}, 32'd0);
    check("rst_valid", {31'd0, level_valid}, 32'd0);
    check("rst_loud", {31'd0, loud}, 32'd0);
    tick();
    resetn = 1'b1;

    // Handshake cadence with read_ready held high.
    enable     = 1'b1;
    read_ready = 1'b1;
    rd_pat     = 13'd0;
    vd_pat     = 13'd0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      rd_pat[e] = read;
      vd_pat[e] = level_valid;
    end
    check("hs_read_pattern", {19'd0, rd_pat}, 32'h0492);
    check("hs_valid_pattern", {19'd0, vd_pat}, 32'h1000);
    tick();
    check("hs_valid_one_cycle", {31'd0, level_valid}, 32'd0);
    do_reset();

    // Peak over a window, then cleared for the next window.
    pop_sample(24'h010000, 24'd0, "pk1");
    pop_sample(24'hFF0000, 24'd0, "pk2");
    pop_sample(24'h000100, 24'd0, "pk3");
    check("pk_valid_early", {31'd0, level_valid}, 32'd0);
    pop_sample(24'h000000, 24'd0, "pk4");
    check("pk_valid", {31'd0, level_valid}, 32'd1);
    check("pk_level", {16'd0, level}, 32'h0200);
    check("pk_loud", {31'd0, loud}, 32'd0);
    tick();
    check("pk_valid_drop", {31'd0, level_valid}, 32'd0);
    check("pk_level_hold", {16'd0, level}, 32'h0200);
    window4(24'h000100, 24'd0, 16'h0002, 1'b0, "pk_next");

    // Saturation and stereo max.
    window4(24'h800000, 24'h000080, 16'hFFFF, 1'b1, "sat_left");
    window4(24'h000000, 24'h7FFF80, 16'hFFFF, 1'b1, "sat_right");

    // Hysteresis from a clean reset.
    do_reset();
    window4(24'h100000, 24'd0, 16'h2000, 1'b1, "hy_2000");
    window4(24'd0, 24'hF40000, 16'h1800, 1'b1, "hy_1800");
    window4(24'h080000, 24'd0, 16'h1000, 1'b1, "hy_1000");
    window4(24'h07FF80, 24'd0, 16'h0FFF, 1'b0, "hy_0fff");

    // Reset during ACK after two samples of a window.
    window4(24'h100000, 24'd0, 16'h2000, 1'b1, "mr_pre");
    pop_sample(24'h100000, 24'd0, "mr1");
    pop_sample(24'h100000, 24'd0, "mr2");
    l_in       = 24'h100000;
    read_ready = 1'b1;
    any_read   = 1'b0;
    for (int i = 0; i < 8 && !any_read; i++) begin
      tick();
      if (read === 1'b1) any_read = 1'b1;
    end
    check("mr_in_ack", {31'd0, any_read}, 32'd1);
    resetn = 1'b0;
    #1;
    check("mr_read", {31'd0, read}, 32'd0);
    check("mr_level", {16'd0, level}, 32'd0);
    check("mr_valid", {31'd0, level_valid}, 32'd0);
    check("mr_loud", {31'd0, loud}, 32'd0);
    read_ready = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    check("mr_no_pop_after_reset", {31'd0, read}, 32'd0);
    pop_sample(24'h000100, 24'd0, "mr_a");
    pop_sample(24'h000100, 24'd0, "mr_b");
    pop_sample(24'h000100, 24'd0, "mr_c");
    check("mr_valid_after3", {31'd0, level_valid}, 32'd0);
    pop_sample(24'h000100, 24'd0, "mr_d");
    check("mr_valid_after4", {31'd0, level_valid}, 32'd1);
    check("mr_level_fresh", {16'd0, level}, 32'h0002);

    // Enable gating.
    enable     = 1'b0;
    read_ready = 1'b1;
    any_read   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (read !== 1'b0) any_read = 1'b1;
    end
    check("en_no_read", {31'd0, any_read}, 32'd0);
    check("en_level_hold", {16'd0, level}, 32'h0002);
    read_ready = 1'b0;
    enable     = 1'b1;
    pop_sample(24'h100000, 24'd0, "en1");
    pop_sample(24'h100000, 24'd0, "en2");
    enable = 1'b0;
    tick();
    tick();
    enable = 1'b1;
    pop_sample(24'h000100, 24'd0, "en3");
    pop_sample(24'h000100, 24'd0, "en4");
    pop_sample(24'h000100, 24'd0, "en5");
    check("en_valid_after3", {31'd0, level_valid}, 32'd0);
    pop_sample(24'h000100, 24'd0, "en6");
    check("en_valid_after4", {31'd0, level_valid}, 32'd1);
    check("en_level", {16'd0, level}, 32'h0002);
    check("en_loud", {31'd0, loud}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
